// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadrature decoder.
// Resolution-mode encodings and Gray-to-phase conversion live here.
package quad_pkg;

    localparam logic [1:0] RES_X1 = 2'd0;
    localparam logic [1:0] RES_X2 = 2'd1;
    localparam logic [1:0] RES_X4 = 2'd2;

    // Map {a,b} onto its position in the up-counting cycle 00->10->11->01.
    function automatic logic [1:0] gray_phase(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One quadrature channel: synchronizer, level filter, transition decode and
// position counter with optional saturation.
module quad_channel
    import quad_pkg::*;
#(
    parameter int COUNT_W  = 16,
    parameter int FILTER   = 2,
    parameter int SATURATE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               b,
    input  logic [1:0]         res_mode,
    input  logic               clear,
    output logic [COUNT_W-1:0] position,
    output logic               step,
    output logic               dir,
    output logic               error
);

    localparam int CNT_W = $clog2(FILTER + 1);
    localparam logic [COUNT_W-1:0] POS_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
    localparam logic [COUNT_W-1:0] POS_MIN = {1'b1, {(COUNT_W-1){1'b0}}};
    localparam logic [COUNT_W-1:0] ONE     = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         sync1_reg, sync2_reg, cand_reg, filt_reg, prev_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               ref_valid_reg, evt_reg;
    logic [COUNT_W-1:0] pos_reg;
    logic               step_reg, dir_reg, err_reg;

    // Until a reference is loaded every stable level qualifies, so the
    // first accepted state after reset never counts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg     <= 2'b00;
            sync2_reg     <= 2'b00;
            cand_reg      <= 2'b00;
            filt_reg      <= 2'b00;
            prev_reg      <= 2'b00;
            cnt_reg       <= '0;
            ref_valid_reg <= 1'b0;
            evt_reg       <= 1'b0;
        end else begin
            sync1_reg <= {a, b};
            sync2_reg <= sync1_reg;
            evt_reg   <= 1'b0;
            if (ref_valid_reg && sync2_reg == filt_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == '0 || sync2_reg != cand_reg) begin
                cand_reg <= sync2_reg;
                cnt_reg  <= CNT_W'(1);
            end else if (cnt_reg == CNT_W'(FILTER)) begin
                prev_reg      <= filt_reg;
                filt_reg      <= sync2_reg;
                cnt_reg       <= '0;
                evt_reg       <= ref_valid_reg;
                ref_valid_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    logic [1:0]         delta;
    logic               is_up, is_dn, is_bad, x1_hit, counted, count_en;
    logic [COUNT_W-1:0] pos_next;

    always_comb begin
        delta    = gray_phase(filt_reg) - gray_phase(prev_reg);
        is_up    = (delta == 2'd1);
        is_dn    = (delta == 2'd3);
        is_bad   = (delta == 2'd2);
        x1_hit   = (prev_reg == 2'b00 && filt_reg == 2'b10) ||
                   (prev_reg == 2'b10 && filt_reg == 2'b00);
        counted  = is_up | is_dn;
        case (res_mode)
            RES_X1:  counted = x1_hit;
            RES_X2:  counted = (is_up | is_dn) & (prev_reg[1] ^ filt_reg[1]);
            default: counted = is_up | is_dn;
        endcase
        count_en = evt_reg & counted;
        pos_next = pos_reg;
        if (count_en && is_up) begin
            if (!(SATURATE != 0 && pos_reg == POS_MAX))
                pos_next = pos_reg + ONE;
        end else if (count_en && is_dn) begin
            if (!(SATURATE != 0 && pos_reg == POS_MIN))
                pos_next = pos_reg - ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_reg  <= '0;
            step_reg <= 1'b0;
            dir_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            step_reg <= count_en;
            if (count_en)
                dir_reg <= is_up;
            if (clear) begin
                pos_reg <= '0;
                err_reg <= 1'b0;
            end else begin
                pos_reg <= pos_next;
                if (evt_reg && is_bad)
                    err_reg <= 1'b1;
            end
        end
    end

    assign position = pos_reg;
    assign step     = step_reg;
    assign dir      = dir_reg;
    assign error    = err_reg;

endmodule

// File: rtl/quad_decoder.sv
// Multi-channel quadrature decoder: CHANNELS independent quad_channel
// instances sharing clock, reset and resolution mode.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int COUNT_W  = 16,
    parameter int FILTER   = 2,
    parameter int SATURATE = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         a,
    input  logic [CHANNELS-1:0]         b,
    input  logic [1:0]                  res_mode,
    input  logic [CHANNELS-1:0]         clear,
    output logic [CHANNELS*COUNT_W-1:0] position,
    output logic [CHANNELS-1:0]         step,
    output logic [CHANNELS-1:0]         dir,
    output logic [CHANNELS-1:0]         error
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            quad_channel #(
                .COUNT_W  (COUNT_W),
                .FILTER   (FILTER),
                .SATURATE (SATURATE)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .a        (a[gi]),
                .b        (b[gi]),
                .res_mode (res_mode),
                .clear    (clear[gi]),
                .position (position[gi*COUNT_W +: COUNT_W]),
                .step     (step[gi]),
                .dir      (dir[gi]),
                .error    (error[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: table-driven count vectors on a
// 4-channel instance plus directed corner cases on two 4-bit instances.
module tb_quad_decoder;
    import quad_pkg::*;

    logic        clk, reset;
    logic [3:0]  a, b, clear;
    logic [1:0]  res_mode;
    logic [63:0] position;
    logic [3:0]  step, dir, error;

    logic        sa, sb, sclr;
    logic [3:0]  wpos, spos;
    logic        wstep, wdir, werr, sstep, sdir, serr;

    quad_decoder #(.CHANNELS(4), .COUNT_W(16), .FILTER(2), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .res_mode(res_mode), .clear(clear),
        .position(position), .step(step), .dir(dir), .error(error));

    quad_decoder #(.CHANNELS(1), .COUNT_W(4), .FILTER(2), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .a(sa), .b(sb), .res_mode(res_mode), .clear(sclr),
        .position(wpos), .step(wstep), .dir(wdir), .error(werr));

    quad_decoder #(.CHANNELS(1), .COUNT_W(4), .FILTER(2), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .a(sa), .b(sb), .res_mode(res_mode), .clear(sclr),
        .position(spos), .step(sstep), .dir(sdir), .error(serr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int step_cnt [4] = '{0, 0, 0, 0};
    int sstep_cnt = 0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (step[i] === 1'b1) step_cnt[i]++;
        if (sstep === 1'b1) sstep_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0] mode;
        bit         clr;
        bit         up;
        int         cycles;
        int         exp_pos;
        bit         exp_dir;
        int         exp_steps;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    function automatic logic signed [31:0] pos_of(input int ch);
        logic [15:0] t;
        t = position[ch*16 +: 16];
        return {{16{t[15]}}, t};
    endfunction

    function automatic logic [1:0] seq_ab(input bit up, input int p);
        logic [1:0] r;
        case (p)
            0:       r = up ? 2'b10 : 2'b01;
            1:       r = 2'b11;
            2:       r = up ? 2'b01 : 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    task automatic drive_ab(input logic [3:0] mask, input logic [1:0] ab, input int hold);
        for (int i = 0; i < 4; i++)
            if (mask[i]) begin
                a[i] = ab[1];
                b[i] = ab[0];
            end
        repeat (hold) @(negedge clk);
    endtask

    task automatic drive_s(input logic [1:0] ab, input int hold);
        sa = ab[1];
        sb = ab[0];
        repeat (hold) @(negedge clk);
    endtask

    task automatic run_cycles(input logic [3:0] mask, input bit up, input int n);
        for (int c = 0; c < n; c++)
            for (int p = 0; p < 4; p++)
                drive_ab(mask, seq_ab(up, p), 4);
    endtask

    initial begin
        int s0;
        int lat;
        int s_all;

        vecs[0] = '{RES_X4, 1'b1, 1'b1, 16, 64, 1'b1, 64};
        vecs[1] = '{RES_X4, 1'b0, 1'b0, 16,  0, 1'b0, 64};
        vecs[2] = '{RES_X1, 1'b1, 1'b1, 16, 16, 1'b1, 16};
        vecs[3] = '{RES_X2, 1'b1, 1'b1, 16, 32, 1'b1, 32};
        vecs[4] = '{RES_X2, 1'b0, 1'b0, 16,  0, 1'b0, 32};
        vecs[5] = '{RES_X1, 1'b1, 1'b0,  3, -3, 1'b0,  3};
        vecs[6] = '{2'd3,   1'b1, 1'b1,  2,  8, 1'b1,  8};

        reset = 1'b1; a = '0; b = '0; clear = '0; res_mode = RES_X4;
        sa = 1'b0; sb = 1'b0; sclr = 1'b0;
        repeat (3) @(negedge clk);
        for (int ch = 0; ch < 4; ch++)
            check($sformatf("reset_pos%0d", ch), pos_of(ch), 0);
        check("reset_step",  32'(step),  0);
        check("reset_dir",   32'(dir),   0);
        check("reset_error", 32'(error), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Table-driven counting on channel 0
        for (int v = 0; v < 7; v++) begin
            res_mode = vecs[v].mode;
            if (vecs[v].clr) begin
                clear[0] = 1'b1;
                @(negedge clk);
                clear[0] = 1'b0;
            end
            s0 = step_cnt[0];
            run_cycles(4'b0001, vecs[v].up, vecs[v].cycles);
            repeat (12) @(negedge clk);
            check($sformatf("v%0d_pos", v),   pos_of(0), vecs[v].exp_pos);
            check($sformatf("v%0d_dir", v),   32'(dir[0]), 32'(vecs[v].exp_dir));
            check($sformatf("v%0d_steps", v), step_cnt[0] - s0, vecs[v].exp_steps);
            check($sformatf("v%0d_err", v),   32'(error[0]), 0);
            for (int ch = 1; ch < 4; ch++)
                check($sformatf("v%0d_other%0d", v, ch), pos_of(ch), 0);
        end

        // Latency from first sampling edge to step pulse
        res_mode = RES_X4;
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        a[0] = 1'b1;
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (step[0] === 1'b1) begin
                lat = k;
                break;
            end
        end
        @(negedge clk);
        check("latency", lat, 5);
        drive_ab(4'b0001, 2'b11, 4);
        drive_ab(4'b0001, 2'b01, 4);
        drive_ab(4'b0001, 2'b00, 12);
        check("lat_cycle_pos", pos_of(0), 4);

        // Single-cycle glitch on a is filtered out
        s0 = step_cnt[0];
        a[0] = 1'b1;
        @(negedge clk);
        a[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("glitch_steps", step_cnt[0] - s0, 0);
        check("glitch_pos",   pos_of(0), 4);

        // Both bits change: error, no count, dir kept
        s0 = step_cnt[0];
        drive_ab(4'b0001, 2'b11, 12);
        check("dbl_error", 32'(error[0]), 1);
        check("dbl_pos",   pos_of(0), 4);
        check("dbl_steps", step_cnt[0] - s0, 0);
        check("dbl_dir",   32'(dir[0]), 1);
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        @(negedge clk);
        check("clr_pos",   pos_of(0), 0);
        check("clr_error", 32'(error[0]), 0);
        drive_ab(4'b0001, 2'b01, 12);
        check("post_clr_pos", pos_of(0), 1);

        // Clear coincident with an up count
        s0 = step_cnt[0];
        a[0] = 1'b0; b[0] = 1'b0;
        repeat (5) @(negedge clk);
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        repeat (8) @(negedge clk);
        check("coinc_pos",   pos_of(0), 0);
        check("coinc_steps", step_cnt[0] - s0, 1);
        check("coinc_error", 32'(error[0]), 0);

        // 4-bit wrap vs saturate
        drive_s(2'b10, 4); drive_s(2'b11, 4); drive_s(2'b01, 4); drive_s(2'b00, 4);
        drive_s(2'b10, 4); drive_s(2'b11, 4); drive_s(2'b01, 12);
        check("wrap_pre", {{28{wpos[3]}}, wpos}, 7);
        check("sat_pre",  {{28{spos[3]}}, spos}, 7);
        s0 = sstep_cnt;
        drive_s(2'b00, 12);
        check("wrap_pos",   {{28{wpos[3]}}, wpos}, -8);
        check("sat_pos",    {{28{spos[3]}}, spos}, 7);
        check("sat_steps",  sstep_cnt - s0, 1);
        check("sat_dir",    32'(sdir), 1);

        // All channels stepping together
        drive_ab(4'hF, 2'b10, 4); drive_ab(4'hF, 2'b11, 4);
        drive_ab(4'hF, 2'b01, 4); drive_ab(4'hF, 2'b00, 4);
        drive_ab(4'hF, 2'b10, 4); drive_ab(4'hF, 2'b11, 12);
        for (int ch = 0; ch < 4; ch++)
            check($sformatf("all_pos%0d", ch), pos_of(ch), 6);
        check("all_dir", 32'(dir), 15);

        // Reset in the middle of a pending qualification, a=b=1 held
        drive_ab(4'hF, 2'b01, 2);
        a = 4'hF; b = 4'hF;
        reset = 1'b1;
        #1;
        for (int ch = 0; ch < 4; ch++)
            check($sformatf("mid_rst_pos%0d", ch), pos_of(ch), 0);
        check("mid_rst_dir",   32'(dir),   0);
        check("mid_rst_error", 32'(error), 0);
        check("mid_rst_step",  32'(step),  0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        s_all = step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3];
        repeat (20) @(negedge clk);
        check("rel_error", 32'(error), 0);
        check("rel_steps", step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3] - s_all, 0);
        for (int ch = 0; ch < 4; ch++)
            check($sformatf("rel_pos%0d", ch), pos_of(ch), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
